lec6_gray_checker: RTL and testbench

- Self-contained, clocked stimulus generator and response checker for the 3-input combinational function Y = (A&B)|(B&C).
- Drives the Gray-code vector sequence 000,001,011,010,110,111,101,100 (A is MSB) into a unit under test and samples the UUT's Y for each vector.
- Compares each sample against the internally computed expected value and reports a pass/fail summary.
- Sits at the other end of the UUT interface, replacing the behavioural testbench with synthesizable on-chip self-test logic.

---
 rtl/lec6_gray_checker_if.sv | 11 +
 rtl/lec6_gray_checker.sv | 122 ++++++++++++
 tb/tb_lec6_gray_checker.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lec6_gray_checker_if.sv
// Stimulus/response link between the Gray-code checker and the unit under test.
// The checker drives the three stimulus bits and reads back the single response.
interface lec6_gray_checker_if;
  logic a_o;
  logic b_o;
  logic c_o;
  logic y_i;

  modport master (output a_o, output b_o, output c_o, input y_i);
  modport slave  (input a_o, input b_o, input c_o, output y_i);
endinterface

// File: rtl/lec6_gray_checker.sv
// On-chip self-test for Y = (A&B)|(B&C): walks the 3-bit Gray sequence, holds each
// vector for HOLD_CYCLES clocks, samples the response on the last held cycle and
// accumulates a mismatch count, the first failing vector and a pass flag.
module lec6_gray_checker #(
  parameter int HOLD_CYCLES = 5,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  lec6_gray_checker_if.master        uut,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [3:0]                 err_count,
  output logic                       fail_valid,
  output logic [2:0]                 first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] hold;
  logic [2:0]       vec;

  logic             exp_y;
  logic             mismatch;
  logic             sample;
  logic [3:0]       err_next;

  function automatic logic [2:0] gray(input logic [2:0] i);
    return i ^ (i >> 1);
  endfunction

  // Stimulus comes straight from the vector register, so the UUT sees glitch-free inputs.
  assign uut.a_o = vec[2];
  assign uut.b_o = vec[1];
  assign uut.c_o = vec[0];

  // Expected response for the vector currently on the UUT inputs.
  assign exp_y    = (vec[2] & vec[1]) | (vec[1] & vec[0]);
  assign mismatch = (uut.y_i != exp_y);
  assign sample   = (hold == HOLD_LAST);
  assign err_next = err_count + 4'(mismatch);

  // Sequencer, sampler and result registers in one FSM.
  // NOTE: asynchronous reset puts every register, including results, in a known state at once; sequential state uses <= so all registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 3'd0;
      hold           <= '0;
      vec            <= 3'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 4'd0;
      fail_valid     <= 1'b0;
      first_fail_vec <= 3'd0;
    end else begin
      // NOTE: done defaults low here so it can only ever be a single-cycle pulse.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= 4'd0;
            fail_valid     <= 1'b0;
            first_fail_vec <= 3'd0;
            idx            <= 3'd0;
            hold           <= '0;
            vec            <= gray(3'd0);
          end
        end

        RUN: begin
          if (!sample) begin
            hold <= hold + CNT_W'(1);
          end else begin
            hold <= '0;
            if (mismatch) begin
              err_count <= err_next;
              if (!fail_valid) begin
                fail_valid     <= 1'b1;
                first_fail_vec <= vec;
              end
            end
            if (idx != 3'd7) begin
              idx <= idx + 3'd1;
              vec <= gray(idx + 3'd1);
            end else begin
              state <= FINISH;
              idx   <= 3'd0;
              vec   <= 3'd0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 4'd0);
            end
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lec6_gray_checker.sv
// Bench for lec6_gray_checker: two instances (HOLD_CYCLES 5 and 1) driven by
// behavioural UUT models; expectations are queued at start and checked by a monitor.
module tb_lec6_gray_checker;

  localparam int H0 = 5;
  localparam int H1 = 1;

  typedef enum {Y_OK, Y_ZERO, Y_INV, Y_MASK} ymode_t;

  typedef struct {
    int         dut;
    int         start_edge;
    int         hold;
    int         err;
    bit         fv;
    logic [2:0] first;
    bit         pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start [2];
  logic       busy_s [2];
  logic       done_s [2];
  logic       pass_s [2];
  logic [3:0] err_s [2];
  logic       fv_s [2];
  logic [2:0] ffv_s [2];
  logic [2:0] vec_s [2];
  ymode_t     mode [2];
  logic [7:0] mask [2];

  logic [2:0] gray_seq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  lec6_gray_checker_if if0 ();
  lec6_gray_checker_if if1 ();

  function automatic logic f_ref(input logic [2:0] v);
    return (v[2] & v[1]) | (v[1] & v[0]);
  endfunction

  function automatic logic uut_y(input ymode_t m, input logic [7:0] mk, input logic [2:0] v);
    case (m)
      Y_OK:    return f_ref(v);
      Y_ZERO:  return 1'b0;
      Y_INV:   return !f_ref(v);
      default: return f_ref(v) ^ mk[v];
    endcase
  endfunction

  assign vec_s[0] = {if0.a_o, if0.b_o, if0.c_o};
  assign vec_s[1] = {if1.a_o, if1.b_o, if1.c_o};
  assign if0.y_i  = uut_y(mode[0], mask[0], vec_s[0]);
  assign if1.y_i  = uut_y(mode[1], mask[1], vec_s[1]);

  lec6_gray_checker #(.HOLD_CYCLES(H0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .uut(if0),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
    .fail_valid(fv_s[0]), .first_fail_vec(ffv_s[0])
  );

  lec6_gray_checker #(.HOLD_CYCLES(H1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .uut(if1),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]),
    .fail_valid(fv_s[1]), .first_fail_vec(ffv_s[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hold_of(input int d);
    return (d == 0) ? H0 : H1;
  endfunction

  // Reference: walk the Gray list and count where the modelled UUT disagrees with Y.
  function automatic exp_t model(input int d, input ymode_t m, input logic [7:0] mk);
    exp_t e;
    e.dut = d; e.hold = hold_of(d); e.start_edge = 0;
    e.err = 0; e.fv = 0; e.first = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (uut_y(m, mk, gray_seq[i]) != f_ref(gray_seq[i])) begin
        e.err++;
        if (!e.fv) begin
          e.fv = 1;
          e.first = gray_seq[i];
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  // Monitor: checks the driven vector each busy cycle and the results on done.
  always @(negedge clk) begin : mon
    exp_t e;
    int   k;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (done_s[d]) begin
          if (sb_q.size() == 0 || sb_q[0].dut != d) begin
            check($sformatf("unexpected_done%0d", d), 1, 0);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("latency%0d", d), edge_cnt - e.start_edge, 8 * e.hold);
            check($sformatf("pass%0d", d), pass_s[d], e.pass);
            check($sformatf("err_count%0d", d), err_s[d], e.err);
            check($sformatf("fail_valid%0d", d), fv_s[d], e.fv);
            if (e.fv) check($sformatf("first_fail_vec%0d", d), ffv_s[d], e.first);
            check($sformatf("busy_at_done%0d", d), busy_s[d], 0);
            check($sformatf("vec_at_done%0d", d), vec_s[d], 0);
          end
        end else if (busy_s[d]) begin
          if (sb_q.size() == 0 || sb_q[0].dut != d) begin
            check($sformatf("unexpected_busy%0d", d), 1, 0);
          end else begin
            k = (edge_cnt - sb_q[0].start_edge) / sb_q[0].hold;
            if (k > 7) check($sformatf("busy_too_long%0d", d), k, 7);
            else       check($sformatf("vector%0d", d), vec_s[d], gray_seq[k]);
          end
        end
      end
    end
  end

  // One run: queue the expectation, pulse start, optionally re-pulse mid-run or
  // during FINISH, wait (bounded) for the monitor to retire it, then check idle results.
  task automatic run(input int d, input ymode_t m, input logic [7:0] mk,
                     input int repulse, input bit finish_poke, input bit idle_chk);
    exp_t e;
    int   n;
    @(negedge clk);
    mode[d] = m;
    mask[d] = mk;
    e = model(d, m, mk);
    e.start_edge = edge_cnt + 1;
    sb_q.push_back(e);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    if (repulse > 0) begin
      while (edge_cnt - e.start_edge < repulse) @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
    end
    n = 0;
    while (sb_q.size() != 0 && n < 8 * e.hold + 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 0, 1);
      sb_q.delete();
    end
    if (finish_poke) begin
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      check("finish_start_ignored", busy_s[d], 0);
    end
    if (idle_chk) begin
      repeat (3) @(negedge clk);
      check("idle_busy", busy_s[d], 0);
      check("idle_vec", vec_s[d], 0);
      check("idle_pass", pass_s[d], e.pass);
      check("idle_err_count", err_s[d], e.err);
      check("idle_fail_valid", fv_s[d], e.fv);
      if (e.fv) check("idle_first_fail_vec", ffv_s[d], e.first);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : stim
    exp_t e;
    rst_n = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    mode[0] = Y_OK;  mode[1] = Y_OK;
    mask[0] = 8'h00; mask[1] = 8'h00;
    #12;
    for (int d = 0; d < 2; d++) begin
      check("rst_vec", vec_s[d], 0);
      check("rst_busy", busy_s[d], 0);
      check("rst_done", done_s[d], 0);
      check("rst_pass", pass_s[d], 0);
      check("rst_err_count", err_s[d], 0);
      check("rst_fail_valid", fv_s[d], 0);
      check("rst_first_fail_vec", ffv_s[d], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios on the HOLD_CYCLES=5 instance.
    run(0, Y_OK,   8'h00, 0,          0, 1);
    run(0, Y_ZERO, 8'h00, 0,          1, 1);
    run(0, Y_INV,  8'h00, 0,          0, 0);
    run(0, Y_OK,   8'h00, 3 * H0 + 1, 0, 0);
    run(0, Y_INV,  8'h00, 0,          0, 0);
    run(0, Y_OK,   8'h00, 0,          0, 1);

    // Reset in the middle of vector 110 aborts with no done.
    @(negedge clk);
    mode[0] = Y_OK;
    e = model(0, Y_OK, 8'h00);
    e.start_edge = edge_cnt + 1;
    sb_q.push_back(e);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    while (edge_cnt - e.start_edge < 4 * H0 + 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_vec", vec_s[0], 0);
    check("midrst_busy", busy_s[0], 0);
    check("midrst_done", done_s[0], 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8 * H0 + 5) @(negedge clk);
    check("post_rst_busy", busy_s[0], 0);
    run(0, Y_OK, 8'h00, 0, 0, 1);

    // HOLD_CYCLES=1 instance.
    run(1, Y_OK,   8'h00, 0, 0, 1);
    run(1, Y_ZERO, 8'h00, 0, 1, 1);

    // Randomised faulty UUTs on either instance.
    for (int i = 0; i < 8; i++) begin
      run($urandom_range(0, 1), Y_MASK, 8'($urandom), 0, 1'($urandom_range(0, 1)), 1);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
